// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT range-filter sequencer.
// State encoding, function code and word width.
package iotdf_pkg;

   localparam int WORD_W = 128;

   localparam logic [2:0] ST_IDLE = 3'b000;
   localparam logic [2:0] ST_LOAD = 3'b001;
   localparam logic [2:0] ST_PROC = 3'b010;
   localparam logic [2:0] ST_OUT  = 3'b011;

   localparam logic [2:0] FN_RANGE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      LOAD = ST_LOAD,
      PROC = ST_PROC,
      OUT  = ST_OUT
   } state_t;

endpackage

// File: rtl/iotdf_byte_asm.sv
// Byte-serial word assembler: MSB-first shift register
// plus byte index, with shift/clear controls from the FSM.
module iotdf_byte_asm
   import iotdf_pkg::*;
#(
   parameter int WORD_BYTES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    shift,
   input  logic                    clear,
   input  logic [7:0]              byte_in,
   output logic [8*WORD_BYTES-1:0] data,
   output logic [7:0]              cycle_cnt,
   output logic                    last
);

   assign last = (cycle_cnt == 8'(WORD_BYTES - 1));

   // shift accepted bytes in and track the byte index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data      <= '0;
         cycle_cnt <= '0;
      end else begin
         if (shift)
            data <= {data[8*WORD_BYTES-9:0], byte_in};
         if (clear)
            cycle_cnt <= '0;
         else if (shift)
            cycle_cnt <= cycle_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/iotdf_filter_ctrl.sv
// Sequencer for the IoT range-filter datapath.
// Optional pass counter output enabled by PASS_CNT_EN.
module iotdf_filter_ctrl
   import iotdf_pkg::*;
#(
   parameter int WORD_BYTES  = 16,
   parameter int ROUND_WORDS = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_en,
   input  logic [7:0]              iot_in,
   input  logic [2:0]              fn_sel,
   input  logic [8*WORD_BYTES-1:0] filt_result,
   input  logic                    filt_hit,
   output logic [2:0]              state,
   output logic [8*WORD_BYTES-1:0] data,
   output logic [5:0]              cnt,
   output logic [7:0]              cycle_cnt,
   output logic [2:0]              fn_sel_q,
   output logic                    busy,
   output logic                    valid,
   output logic [8*WORD_BYTES-1:0] iot_out,
   output logic                    round_done
`ifdef PASS_CNT_EN
   ,
   output logic [7:0]              pass_cnt
`endif
);

   localparam logic [5:0] CNT_LAST = 6'(ROUND_WORDS - 1);

   state_t cur, nxt;
   logic   accept;
   logic   last;
   logic   busy_d;
   logic   valid_d;
   logic   proc;
   logic   wrap;

   assign state = cur;
   assign proc  = (cur == PROC);
   assign wrap  = (cnt == CNT_LAST);

   iotdf_byte_asm #(
      .WORD_BYTES(WORD_BYTES)
   ) u_asm (
      .clk      (clk),
      .rst      (rst),
      .shift    (accept),
      .clear    (accept && last),
      .byte_in  (iot_in),
      .data     (data),
      .cycle_cnt(cycle_cnt),
      .last     (last)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cur <= IDLE;
      else
         cur <= nxt;
   end

   // next state, byte acceptance and handshake flags
   always_comb begin
      nxt     = cur;
      busy_d  = busy;
      valid_d = 1'b0;
      accept  = 1'b0;
      unique case (cur)
         IDLE, LOAD: begin
            if (in_en && !busy) begin
               accept = 1'b1;
               if (last) begin
                  nxt    = PROC;
                  busy_d = 1'b1;
               end else begin
                  nxt = LOAD;
               end
            end
         end
         PROC: begin
            if (filt_hit) begin
               nxt     = OUT;
               valid_d = 1'b1;
            end else begin
               nxt    = LOAD;
               busy_d = 1'b0;
            end
         end
         OUT: begin
            nxt    = LOAD;
            busy_d = 1'b0;
         end
         default: nxt = IDLE;
      endcase
   end

   // word counter, captured result and round bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy       <= 1'b0;
         valid      <= 1'b0;
         cnt        <= '0;
         round_done <= 1'b0;
         iot_out    <= '0;
         fn_sel_q   <= '0;
      end else begin
         busy       <= busy_d;
         valid      <= valid_d;
         round_done <= proc && wrap;
         if (proc)
            cnt <= wrap ? 6'd0 : cnt + 6'd1;
         if (proc && filt_hit)
            iot_out <= filt_result;
         if (accept && cycle_cnt == 8'd0 && cnt == 6'd0)
            fn_sel_q <= fn_sel;
      end
   end

`ifdef PASS_CNT_EN
   // saturating count of passing words, cleared after each round
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pass_cnt <= '0;
      else if (round_done)
         pass_cnt <= '0;
      else if (valid && pass_cnt != 8'hFF)
         pass_cnt <= pass_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_iotdf_filter_ctrl.sv
// Self-checking bench for iotdf_filter_ctrl.
// Vector table, scoreboard queue and corner sequences.
module tb_iotdf_filter_ctrl;

   localparam logic [127:0] LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [127:0] HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_en = 1'b0;
   logic [7:0]   iot_in = 8'h00;
   logic [2:0]   fn_sel = 3'd4;
   logic [127:0] filt_result;
   logic         filt_hit;
   logic [2:0]   state;
   logic [127:0] data;
   logic [5:0]   cnt;
   logic [7:0]   cycle_cnt;
   logic [2:0]   fn_sel_q;
   logic         busy;
   logic         valid;
   logic [127:0] iot_out;
   logic         round_done;
`ifdef PASS_CNT_EN
   logic [7:0]   pass_cnt;
`endif

   int total = 0;
   int bad = 0;
   int vcount = 0;
   int rdcount = 0;
   int both = 0;
   logic [127:0] exp_q[$];
   logic [127:0] mon_e;

   typedef struct {
      logic [127:0] word;
      logic         hit;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   // filter model: strict window compare, responds only in PROC
   assign filt_result = data;
   assign filt_hit = (state == 3'b010) && (data > LO) && (data < HI);

   iotdf_filter_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_en      (in_en),
      .iot_in     (iot_in),
      .fn_sel     (fn_sel),
      .filt_result(filt_result),
      .filt_hit   (filt_hit),
      .state      (state),
      .data       (data),
      .cnt        (cnt),
      .cycle_cnt  (cycle_cnt),
      .fn_sel_q   (fn_sel_q),
      .busy       (busy),
      .valid      (valid),
      .iot_out    (iot_out),
      .round_done (round_done)
`ifdef PASS_CNT_EN
      ,
      .pass_cnt   (pass_cnt)
`endif
   );

   function automatic logic model_hit(input logic [127:0] w);
      return (w > LO) && (w < HI);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got timeout want progress", nm);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) tmo("wait_ready");
   endtask

   task automatic wait_load();
      int n;
      n = 0;
      while (!(state == 3'b001 && !busy) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) tmo("wait_load");
   endtask

   task automatic send_byte(input logic [7:0] b);
      wait_ready();
      in_en  = 1'b1;
      iot_in = b;
      @(posedge clk); #1;
      in_en  = 1'b0;
   endtask

   task automatic send_word(input logic [127:0] w);
      for (int i = 0; i < 16; i++)
         send_byte(w[127-8*i -: 8]);
   endtask

   task automatic chk_reset_outs();
      chk("rst state", 128'(state), 0);
      chk("rst data", data, 0);
      chk("rst cnt", 128'(cnt), 0);
      chk("rst cycle_cnt", 128'(cycle_cnt), 0);
      chk("rst fn_sel_q", 128'(fn_sel_q), 0);
      chk("rst busy", 128'(busy), 0);
      chk("rst valid", 128'(valid), 0);
      chk("rst iot_out", iot_out, 0);
      chk("rst round_done", 128'(round_done), 0);
   endtask

   // scoreboard: pop expected word on every valid pulse
   always @(negedge clk) begin
      if (rst) begin
         if (valid) begin
            vcount++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected valid: got %h want none", iot_out);
            end else begin
               mon_e = exp_q.pop_front();
               chk("iot_out", iot_out, mon_e);
            end
         end
         if (round_done) begin
            rdcount++;
            if (valid) both++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      int v0;
      int r0;
      int b0;
      int n;
      logic [127:0] w;

      vecs[0] = '{128'h1234_5678_9ABC_DEF0_0000_0000_0000_0000, 1'b0};
      vecs[1] = '{128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[2] = '{128'h7000_0000_0000_0000_0000_0000_0000_0000, 1'b1};
      vecs[3] = '{128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[4] = '{128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b1};
      vecs[5] = '{128'h0000_0000_0000_0000_0000_0000_0000_0000, 1'b0};
      vecs[6] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[7] = '{128'h9ABC_DEF0_1122_3344_5566_7788_99AA_BBCC, 1'b1};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs();
      rst = 1'b1;
      @(posedge clk); #1;

      // passing word: PROC one cycle, valid one cycle
      w = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
      exp_q.push_back(w);
      send_word(w);
      chk("p1 state", 128'(state), 128'(3'b010));
      chk("p1 busy", 128'(busy), 1);
      chk("p1 data", data, w);
      chk("p1 cycle_cnt", 128'(cycle_cnt), 0);
      chk("p1 fn_sel_q", 128'(fn_sel_q), 4);
      @(posedge clk); #1;
      chk("p2 state", 128'(state), 128'(3'b011));
      chk("p2 valid", 128'(valid), 1);
      chk("p2 busy", 128'(busy), 1);
      @(posedge clk); #1;
      chk("p3 valid", 128'(valid), 0);
      chk("p3 busy", 128'(busy), 0);
      chk("p3 state", 128'(state), 128'(3'b001));
      chk("p3 iot_out hold", iot_out, w);
      chk("p3 cnt", 128'(cnt), 1);

      // rejected word
      send_word(128'h1234_0000_0000_0000_0000_0000_0000_0000);
      chk("r1 state", 128'(state), 128'(3'b010));
      @(posedge clk); #1;
      chk("r2 state", 128'(state), 128'(3'b001));
      chk("r2 busy", 128'(busy), 0);
      chk("r2 valid", 128'(valid), 0);
      chk("r2 cnt", 128'(cnt), 2);

      // vector table including both window bounds
      for (int i = 0; i < 8; i++) begin
         c0 = int'(cnt);
         v0 = vcount;
         if (vecs[i].hit) exp_q.push_back(vecs[i].word);
         send_word(vecs[i].word);
         chk("vec data", data, vecs[i].word);
         wait_load();
         @(posedge clk); #1;
         chk("vec pulses", 128'(vcount - v0), 128'(vecs[i].hit));
         chk("vec cnt", 128'(cnt), 128'((c0 + 1) % 64));
      end

      // bytes offered while busy are dropped
      w = 128'h8888_8888_8888_8888_8888_8888_8888_8888;
      exp_q.push_back(w);
      send_word(w);
      in_en  = 1'b1;
      iot_in = 8'hAA;
      n = 0;
      while (busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) tmo("busy window");
      chk("drop window len", 128'(n), 2);
      w = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
      send_word(w);
      chk("drop data", data, w);
      wait_load();

      // full round: single round_done, fn_sel held until next round
      rst = 1'b0;
      #1;
      chk("rst2 cnt", 128'(cnt), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      fn_sel = 3'd4;
      r0 = rdcount;
      b0 = both;
      for (int i = 0; i < 64; i++) begin
         if (i == 10) fn_sel = 3'd2;
         w = (i % 8 == 7) ? {8'h90, 120'(i)} : {8'h10, 120'(i)};
         if (model_hit(w)) exp_q.push_back(w);
         send_word(w);
         if (i == 0 || i == 10 || i == 63)
            chk("round fn_sel_q", 128'(fn_sel_q), 4);
         wait_load();
      end
      @(posedge clk); #1;
      chk("round_done count", 128'(rdcount - r0), 1);
      chk("round_done with valid", 128'(both - b0), 1);
      chk("round cnt wrap", 128'(cnt), 0);
      send_word({8'h20, 120'd0});
      chk("next round fn_sel_q", 128'(fn_sel_q), 2);
      wait_load();

      // reset after byte 7 discards the partial word
      for (int i = 0; i < 7; i++)
         send_byte(8'h11 * 8'(i + 1));
      chk("pre-rst cycle_cnt", 128'(cycle_cnt), 7);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_outs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post-rst cycle_cnt", 128'(cycle_cnt), 0);
      w = 128'h8123_4567_89AB_CDEF_0011_2233_4455_6677;
      exp_q.push_back(w);
      v0 = vcount;
      send_word(w);
      chk("post-rst data", data, w);
      wait_load();
      @(posedge clk); #1;
      chk("post-rst pulse", 128'(vcount - v0), 1);
      chk("post-rst cnt", 128'(cnt), 1);

      repeat (3) @(posedge clk);
      #1;
      chk("queue empty", 128'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
